// File: rtl/sar_seg_ctrl.sv
// sar_seg_ctrl: successive-approximation controller for a segmented-DAC SAR ADC.
// Runs an N_BITS binary search against an external comparator. The DAC is driven
// as a thermometer-coded MSB segment plus binary LSBs, and the result is returned
// through a start/busy/done handshake.
module sar_seg_ctrl #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned M_THERM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       cont,
  input  logic                       abort,
  input  logic                       cmp,
  output logic                       sample,
  output logic                       busy,
  output logic                       done,
  output logic [(2**M_THERM)-2:0]    dac_therm,
  output logic [N_BITS-M_THERM-1:0]  dac_bin,
  output logic [N_BITS-1:0]          result
);

  localparam int unsigned THERM_W = (1 << M_THERM) - 1;
  localparam int unsigned BIN_W   = N_BITS - M_THERM;
  localparam int unsigned IDX_W   = $clog2(N_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [N_BITS-1:0]   code_q, code_d;
  logic [N_BITS-1:0]   result_q, result_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                sample_q, busy_q, done_q;
  logic [M_THERM-1:0]  msb_c;

  // State, working code, bit index, result and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      sample_q <= (state_d == S_SAMPLE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
    end
  end

  // Next-state logic: binary search, one trial bit per CONV cycle; abort wins over updates.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        code_d = '0;
        idx_d  = '0;
        if (start) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          code_d  = '0;
          idx_d   = '0;
        end else begin
          state_d            = S_CONV;
          code_d             = '0;
          code_d[N_BITS-1]   = 1'b1;
          idx_d              = IDX_W'(N_BITS - 1);
        end
      end
      S_CONV: begin
        if (abort) begin
          state_d = S_IDLE;
          code_d  = '0;
          idx_d   = '0;
        end else begin
          code_d[idx_q] = cmp;
          if (idx_q != '0) begin
            code_d[idx_q - IDX_W'(1)] = 1'b1;
            idx_d                     = idx_q - IDX_W'(1);
          end else begin
            state_d  = S_DONE;
            result_d = code_d;
          end
        end
      end
      S_DONE: begin
        code_d  = '0;
        idx_d   = '0;
        state_d = (cont || start) ? S_SAMPLE : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        code_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Generic thermometer decode of the MSB segment: value v lights bits [v-1:0].
  always_comb begin
    msb_c     = code_q[N_BITS-1 -: M_THERM];
    dac_therm = '0;
    for (int unsigned j = 0; j < THERM_W; j++) begin
      dac_therm[j] = (32'(msb_c) > j);
    end
  end

  assign dac_bin = code_q[BIN_W-1:0];
  assign sample  = sample_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_sar_seg_ctrl.sv
// Bench for sar_seg_ctrl: directed conversions against a comparator model that
// reads the DAC outputs, with a result/latency scoreboard per instance.
module tb_sar_seg_ctrl;

  typedef struct {
    logic [31:0] val;
    logic [31:0] cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] cyc;
  int          n_vec;
  int          n_err;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];

  // Main instance (8,4)
  logic        start0, cont0, abort0, cmp0;
  logic        sample0, busy0, done0;
  logic [14:0] dac_therm0;
  logic [3:0]  dac_bin0;
  logic [7:0]  result0;
  logic [7:0]  vin0;

  // Sweep instances share control inputs
  logic        start_s, cont_s, abort_s;
  logic        cmp1, cmp2, cmp3;
  logic        sample1, busy1, done1, sample2, busy2, done2, sample3, busy3, done3;
  logic [2:0]  dac_therm1;
  logic [3:0]  dac_bin1;
  logic [5:0]  result1;
  logic [30:0] dac_therm2;
  logic [6:0]  dac_bin2;
  logic [11:0] result2;
  logic [0:0]  dac_therm3;
  logic [8:0]  dac_bin3;
  logic [9:0]  result3;
  logic [5:0]  vin1;
  logic [11:0] vin2;
  logic [9:0]  vin3;

  sar_seg_ctrl #(.N_BITS(8), .M_THERM(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cont(cont0), .abort(abort0), .cmp(cmp0),
    .sample(sample0), .busy(busy0), .done(done0),
    .dac_therm(dac_therm0), .dac_bin(dac_bin0), .result(result0)
  );

  sar_seg_ctrl #(.N_BITS(6), .M_THERM(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cont(cont_s), .abort(abort_s), .cmp(cmp1),
    .sample(sample1), .busy(busy1), .done(done1),
    .dac_therm(dac_therm1), .dac_bin(dac_bin1), .result(result1)
  );

  sar_seg_ctrl #(.N_BITS(12), .M_THERM(5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cont(cont_s), .abort(abort_s), .cmp(cmp2),
    .sample(sample2), .busy(busy2), .done(done2),
    .dac_therm(dac_therm2), .dac_bin(dac_bin2), .result(result2)
  );

  sar_seg_ctrl #(.N_BITS(10), .M_THERM(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cont(cont_s), .abort(abort_s), .cmp(cmp3),
    .sample(sample3), .busy(busy3), .done(done3),
    .dac_therm(dac_therm3), .dac_bin(dac_bin3), .result(result3)
  );

  // Comparator model: DAC level = (ones in thermometer) * 2^BIN_W + binary LSBs
  assign cmp0 = (32'(vin0) >= ((32'($countones(dac_therm0)) << 4) + 32'(dac_bin0)));
  assign cmp1 = (32'(vin1) >= ((32'($countones(dac_therm1)) << 4) + 32'(dac_bin1)));
  assign cmp2 = (32'(vin2) >= ((32'($countones(dac_therm2)) << 7) + 32'(dac_bin2)));
  assign cmp3 = (32'(vin3) >= ((32'($countones(dac_therm3)) << 9) + 32'(dac_bin3)));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest expected result and cycle
  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      check("done0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("result0", 32'(result0), e.val);
        check("latency0", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1) begin
      check("done1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("result1", 32'(result1), e.val);
        check("latency1", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      check("done2_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e = q2.pop_front();
        check("result2", 32'(result2), e.val);
        check("latency2", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (done3) begin
      check("done3_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check("result3", 32'(result3), e.val);
        check("latency3", cyc, e.cyc);
      end
    end
  end

  // Thermometer outputs must always be a contiguous run of ones from bit 0
  always @(negedge clk) begin
    if (rst_n && busy1) check("therm1_form", 32'(((32'(dac_therm1) + 32'd1) & 32'(dac_therm1)) == 32'd0), 32'd1);
    if (rst_n && busy2) check("therm2_form", 32'(((32'(dac_therm2) + 32'd1) & 32'(dac_therm2)) == 32'd0), 32'd1);
    if (rst_n && busy3) check("therm3_form", 32'(((32'(dac_therm3) + 32'd1) & 32'(dac_therm3)) == 32'd0), 32'd1);
  end

  // Pulse start on the main instance; returns at the negedge after the start edge
  task automatic issue0(input logic [7:0] v, input bit expect_done);
    @(negedge clk);
    vin0   = v;
    start0 = 1'b1;
    if (expect_done) q0.push_back('{32'(v), cyc + 32'd10});
    @(negedge clk);
    start0 = 1'b0;
  endtask

  initial begin
    int sc;
    logic [31:0] c;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    start0 = 1'b0; cont0 = 1'b0; abort0 = 1'b0; vin0 = '0;
    start_s = 1'b0; cont_s = 1'b0; abort_s = 1'b0; vin1 = '0; vin2 = '0; vin3 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sample", 32'(sample0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_therm", 32'(dac_therm0), 32'd0);
    check("rst_bin", 32'(dac_bin0), 32'd0);
    check("rst_result", 32'(result0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: Vin = 0xA5, DAC trace at first and last trial
    issue0(8'hA5, 1'b1);
    check("a5_sample", 32'(sample0), 32'd1);
    check("a5_busy", 32'(busy0), 32'd1);
    check("a5_sample_therm", 32'(dac_therm0), 32'd0);
    @(negedge clk);
    check("a5_first_therm", 32'(dac_therm0), 32'h00FF);
    check("a5_first_bin", 32'(dac_bin0), 32'h0);
    check("a5_first_sample", 32'(sample0), 32'd0);
    repeat (7) @(negedge clk);
    check("a5_last_therm", 32'(dac_therm0), 32'h03FF);
    check("a5_last_bin", 32'(dac_bin0), 32'h5);
    repeat (4) @(negedge clk);
    check("a5_idle_busy", 32'(busy0), 32'd0);
    check("a5_idle_therm", 32'(dac_therm0), 32'd0);

    // 2: boundary inputs
    issue0(8'h00, 1'b1);
    repeat (8) @(negedge clk);
    check("v00_last_therm", 32'(dac_therm0), 32'd0);
    repeat (4) @(negedge clk);
    issue0(8'hFF, 1'b1);
    repeat (8) @(negedge clk);
    check("vff_last_therm", 32'(dac_therm0), 32'h7FFF);
    check("vff_last_bin", 32'(dac_bin0), 32'hF);
    repeat (4) @(negedge clk);

    // 3: abort during the 4th CONV cycle
    issue0(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_sample", 32'(sample0), 32'd0);
    check("abort_therm", 32'(dac_therm0), 32'd0);
    check("abort_bin", 32'(dac_bin0), 32'd0);
    check("abort_result", 32'(result0), 32'hFF);
    repeat (12) @(negedge clk);
    check("abort_result_held", 32'(result0), 32'hFF);

    // 4a: start+abort together in IDLE, then start re-pulsed during CONV
    @(negedge clk);
    vin0 = 8'h37; start0 = 1'b1; abort0 = 1'b1;
    q0.push_back('{32'h37, cyc + 32'd10});
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    repeat (2) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (12) @(negedge clk);

    // 4b: continuous mode, three back-to-back conversions
    @(negedge clk);
    vin0 = 8'h81; cont0 = 1'b1; start0 = 1'b1;
    c = cyc;
    q0.push_back('{32'h81, c + 32'd10});
    q0.push_back('{32'h81, c + 32'd20});
    q0.push_back('{32'h81, c + 32'd30});
    @(negedge clk);
    start0 = 1'b0;
    sc = int'(sample0);
    for (int k = 1; k < 30; k++) begin
      @(negedge clk);
      sc += int'(sample0);
    end
    cont0 = 1'b0;
    check("cont_sample_cycles", 32'(sc), 32'd3);
    repeat (4) @(negedge clk);
    check("cont_stopped", 32'(busy0), 32'd0);

    // 5: async reset mid-CONV, then a fresh conversion
    issue0(8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", 32'(sample0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_done", 32'(done0), 32'd0);
    check("arst_therm", 32'(dac_therm0), 32'd0);
    check("arst_bin", 32'(dac_bin0), 32'd0);
    check("arst_result", 32'(result0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue0(8'h5A, 1'b1);
    repeat (12) @(negedge clk);

    // 6: parameter sweep against random Vin
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      if (it == 0) begin
        vin1 = 6'h3F; vin2 = 12'hFFF; vin3 = 10'h3FF;
      end else begin
        vin1 = 6'($urandom_range(0, 63));
        vin2 = 12'($urandom_range(0, 4095));
        vin3 = 10'($urandom_range(0, 1023));
      end
      start_s = 1'b1;
      q1.push_back('{32'(vin1), cyc + 32'd8});
      q2.push_back('{32'(vin2), cyc + 32'd14});
      q3.push_back('{32'(vin3), cyc + 32'd12});
      @(negedge clk);
      start_s = 1'b0;
      repeat (16) @(negedge clk);
    end

    check("pending0", 32'(q0.size()), 32'd0);
    check("pending1", 32'(q1.size()), 32'd0);
    check("pending2", 32'(q2.size()), 32'd0);
    check("pending3", 32'(q3.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sar_seg_ctrl.md
# sar_seg_ctrl

Parametrised successive-approximation controller for a segmented-DAC SAR ADC. It runs an N-bit binary search against an external comparator. It drives the DAC as M thermometer-coded MSB lines plus binary LSB lines, and returns the binary result through a start/busy/done handshake. It is the sequential successor to the team's fixed 4-bit thermometer-to-binary decoder: the thermometer/binary mapping now happens inside a conversion loop, at any width.

## Interface
Parameters:
- N_BITS, 8, total conversion resolution (≥2).
- M_THERM, 4, MSBs driven as thermometer code (1 ≤ M_THERM ≤ N_BITS-1). Thermometer width T = 2^M_THERM - 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  conversion request, sampled only in IDLE.
- cont  in  1  continuous mode: restart automatically after DONE.
- abort  in  1  cancel the conversion in progress.
- cmp  in  1  comparator output; 1 = Vin ≥ Vdac(trial code).
- sample  out  1  track/hold control, high during SAMPLE.
- busy  out  1  high in SAMPLE, CONV and DONE.
- done  out  1  one-cycle pulse in DONE.
- dac_therm  out  T  thermometer code of code[N_BITS-1 -: M_THERM]; value v sets bits [v-1:0].
- dac_bin  out  N_BITS-M_THERM  binary LSBs code[N_BITS-M_THERM-1:0].
- result  out  N_BITS  last completed conversion result, held until the next DONE.

## Operation
- Internal state: the FSM, a working register code[N_BITS-1:0], and a bit index i (width clog2(N_BITS)).
- States:
  - IDLE: start=1 → SAMPLE.
  - SAMPLE: always → CONV with i=N_BITS-1 and code = 1<<(N_BITS-1).
  - CONV: each cycle code[i] <= cmp.
    - If i>0: code[i-1] <= 1 and i <= i-1.
    - If i==0: → DONE.
  - DONE: result <= final code (cmp applied to bit 0) on DONE entry; done=1.
    - Next state is SAMPLE if cont=1 or start=1, else IDLE.
- abort=1 in SAMPLE or CONV → IDLE next edge, code cleared, result unchanged, no done. abort has priority over all CONV updates. abort is ignored in IDLE and DONE.
- start while busy (outside DONE) is ignored; no queuing.
- dac_therm and dac_bin are decoded combinationally from registered code, so they are glitch-free per cycle. Both are 0 in IDLE and SAMPLE.
- The thermometer decode must be generic over M_THERM. No hard-coded case tables.

## Timing
- Reset: state=IDLE, code=0, i=0, result=0, sample=0, busy=0, done=0, dac_therm=0, dac_bin=0.
- Reset asserted mid-conversion forces all of the above immediately. No done is issued. The next start behaves as from power-up.
- Start accepted at edge E0 produces:
  - SAMPLE during cycle E0→E1;
  - trial bit k presented during cycle E(N_BITS-k) → E(N_BITS-k+1);
  - DONE (done=1, result valid) in cycle E(N_BITS+1) → E(N_BITS+2).
- Latency from start edge to done high is N_BITS+1 cycles. Throughput in continuous mode is one result per N_BITS+2 cycles.
- cmp must be settled for the current trial code before the rising edge that ends the cycle. It is sampled once per CONV cycle.
- result updates only on DONE entry and is stable otherwise, including across abort.
- start and abort asserted in the same cycle in IDLE: start wins. The abort is ignored because nothing is running.

## Test plan
1. N_BITS=8, M_THERM=4, comparator model Vin=0xA5, pulse start. Check:
   - first CONV cycle: dac_therm=0x00FF, dac_bin=0x0;
   - done exactly 9 edges after the start edge, result=0xA5;
   - final-cycle dac_therm=0x03FF, dac_bin=0x5.
2. Boundary inputs:
   - Vin=0x00 → result=0x00, dac_therm=0 at the end.
   - Vin=0xFF → result=0xFF, dac_therm=0x7FFF, dac_bin=0xF.
3. Abort: start with Vin=0x3C, assert abort during the 4th CONV cycle. Check IDLE next cycle, busy=0, no done pulse, result keeps its previous value.
4. Protocol robustness:
   - start re-pulsed during CONV → ignored, single done.
   - cont=1 → back-to-back conversions, done every 10 cycles, sample high 1 cycle each.
5. Async reset: drop rst_n mid-CONV without a clock edge. Check all outputs go to 0 immediately, then a fresh conversion of 0x5A completes correctly.
6. Parameter sweep (N_BITS,M_THERM) = (6,2), (12,5), (10,1) against a random Vin reference model. Check result equals Vin, latency equals N_BITS+1, and dac_therm has exactly code[MSBs] ones.
